// File: rtl/tmr_rx_sched_if.sv
// +----------------------------------------------------------------------------+
// | tmr_rx_sched_if : frame input / decoded output bundle for tmr_rx_sched     |
// | Optional TMR_FORCE_EN adds force_tmr.          Revision: 1.0               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface tmr_rx_sched_if #(
  parameter int DW    = 10,
  parameter int CW    = 14,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [CW-1:0]    cw0;
  logic [CW-1:0]    cw1;
  logic [CW-1:0]    cw2;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic             out_err;
  logic             mode_tmr;
  logic [CNT_W-1:0] err_cnt;
`ifdef TMR_FORCE_EN
  logic             force_tmr;
`endif

  modport slave (
`ifdef TMR_FORCE_EN
    input  force_tmr,
`endif
    input  in_valid, cw0, cw1, cw2,
    output in_ready, out_valid, out_data, out_err, mode_tmr, err_cnt
  );

  modport master (
`ifdef TMR_FORCE_EN
    output force_tmr,
`endif
    output in_valid, cw0, cw1, cw2,
    input  in_ready, out_valid, out_data, out_err, mode_tmr, err_cnt
  );
endinterface

`default_nettype wire

// File: rtl/tmr_rx_sched.sv
// +----------------------------------------------------------------------------+
// | tmr_rx_sched : Dynamic-TMR receive scheduler, one shared Hamming decoder   |
// | Optional macro TMR_FORCE_EN adds force_tmr.    Revision: 1.0               |
// +----------------------------------------------------------------------------+
`default_nettype none

// Hamming(14,10): parity at positions 1,2,4,8 (bit index = position-1).
module ham_dec_14_10 (
  input  logic        en,
  input  logic [13:0] cw,
  output logic [9:0]  data,
  output logic        err
);
  logic [3:0]  syn;
  logic [13:0] fixed;

  always_comb begin
    syn = 4'd0;
    for (int p = 1; p <= 14; p++) begin
      if (cw[p-1]) syn = syn ^ 4'(p);
    end
    fixed = cw;
    for (int p = 1; p <= 14; p++) begin
      if (syn == 4'(p)) fixed[p-1] = ~fixed[p-1];
    end
    data = en ? {fixed[13:8], fixed[6:4], fixed[2]} : 10'd0;
    err  = en & (syn != 4'd0);
  end
endmodule

module tmr_rx_sched #(
  parameter int DW       = 10,
  parameter int CW       = 14,
  parameter int CLEAN_TH = 4,
  parameter int CNT_W    = 8
) (
  input  logic           clk,
  input  logic           rst,
  tmr_rx_sched_if.slave  bus
);
  localparam int             CLW        = $clog2(CLEAN_TH + 1);
  localparam logic [CLW-1:0] c_clean_th = CLW'(CLEAN_TH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DEC0 = 3'd1,
    S_DEC1 = 3'd2,
    S_DEC2 = 3'd3,
    S_VOTE = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic                   in_ready_q, in_ready_d;
  logic [2:0][CW-1:0]     cw_q, cw_d;
  logic                   frame_tmr_q, frame_tmr_d;
  logic [2:0][DW-1:0]     lane_data_q, lane_data_d;
  logic [2:0]             lane_err_q, lane_err_d;
  logic                   out_valid_q, out_valid_d;
  logic [DW-1:0]          out_data_q, out_data_d;
  logic                   out_err_q, out_err_d;
  logic                   mode_q, mode_d;
  logic [CLW-1:0]         clean_q, clean_d;
  logic [CNT_W-1:0]       err_cnt_q, err_cnt_d;

  logic                   dec_en;
  logic [CW-1:0]          dec_cw;
  logic [DW-1:0]          dec_data;
  logic                   dec_err;
  logic [DW-1:0]          vote_data;
  logic                   lanes_differ;
  logic                   frame_err;

  assign dec_en = (state_q == S_DEC0) || (state_q == S_DEC1) || (state_q == S_DEC2);
  assign dec_cw = (state_q == S_DEC1) ? cw_q[1] :
                  (state_q == S_DEC2) ? cw_q[2] : cw_q[0];

  ham_dec_14_10 u_dec (
    .en   (dec_en),
    .cw   (dec_cw),
    .data (dec_data),
    .err  (dec_err)
  );

  assign vote_data    = (lane_data_q[0] & lane_data_q[1]) |
                        (lane_data_q[0] & lane_data_q[2]) |
                        (lane_data_q[1] & lane_data_q[2]);
  assign lanes_differ = (lane_data_q[0] != lane_data_q[1]) || (lane_data_q[1] != lane_data_q[2]);
  // Lanes 1/2 hold stale values in single-lane frames, so they only count for TMR frames.
  assign frame_err    = lane_err_q[0] |
                        (frame_tmr_q & (lane_err_q[1] | lane_err_q[2] | lanes_differ));

  always_comb begin
    state_d     = state_q;
    cw_d        = cw_q;
    frame_tmr_d = frame_tmr_q;
    lane_data_d = lane_data_q;
    lane_err_d  = lane_err_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    mode_d      = mode_q;
    clean_d     = clean_q;
    err_cnt_d   = err_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          cw_d        = {bus.cw2, bus.cw1, bus.cw0};
          frame_tmr_d = mode_q;
          state_d     = S_DEC0;
        end
      end
      S_DEC0: begin
        lane_data_d[0] = dec_data;
        lane_err_d[0]  = dec_err;
        state_d        = frame_tmr_q ? S_DEC1 : S_VOTE;
      end
      S_DEC1: begin
        lane_data_d[1] = dec_data;
        lane_err_d[1]  = dec_err;
        state_d        = S_DEC2;
      end
      S_DEC2: begin
        lane_data_d[2] = dec_data;
        lane_err_d[2]  = dec_err;
        state_d        = S_VOTE;
      end
      S_VOTE: begin
        out_valid_d = 1'b1;
        out_data_d  = frame_tmr_q ? vote_data : lane_data_q[0];
        out_err_d   = frame_err;
        if (frame_err && (err_cnt_q != {CNT_W{1'b1}})) err_cnt_d = err_cnt_q + CNT_W'(1);
        if (frame_tmr_q) begin
          if (frame_err) begin
            clean_d = '0;
          end else if ((clean_q + CLW'(1)) == c_clean_th) begin
            mode_d  = 1'b0;
            clean_d = '0;
          end else begin
            clean_d = clean_q + CLW'(1);
          end
        end else if (frame_err) begin
          mode_d  = 1'b1;
          clean_d = '0;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef TMR_FORCE_EN
    if (bus.force_tmr) begin
      mode_d  = 1'b1;
      clean_d = '0;
    end
`endif

    in_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      cw_q        <= '0;
      frame_tmr_q <= 1'b1;
      lane_data_q <= '0;
      lane_err_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      mode_q      <= 1'b1;
      clean_q     <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      cw_q        <= cw_d;
      frame_tmr_q <= frame_tmr_d;
      lane_data_q <= lane_data_d;
      lane_err_q  <= lane_err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      mode_q      <= mode_d;
      clean_q     <= clean_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_err   = out_err_q;
  assign bus.mode_tmr  = mode_q;
  assign bus.err_cnt   = err_cnt_q;
endmodule

`default_nettype wire

// File: tb/tb_tmr_rx_sched.sv
// +----------------------------------------------------------------------------+
// | tb_tmr_rx_sched : directed bench with a frame-level reference model        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_tmr_rx_sched;
  localparam int DW = 10, CW = 14, CNT_W = 8, CLEAN_TH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tmr_rx_sched_if #(.DW(DW), .CW(CW), .CNT_W(CNT_W)) bus ();
  tmr_rx_sched #(.DW(DW), .CW(CW), .CLEAN_TH(CLEAN_TH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Intended per-lane payload and whether that lane's codeword was corrupted.
  logic [9:0] stim_d [3];
  bit         stim_f [3];

  // Frame-level reference model state.
  bit         m_live = 0;
  logic       m_ready, m_valid, m_err, m_mode, m_perr, m_ptmr;
  logic [9:0] m_data, m_pdata;
  int         m_clean, m_cnt, m_remain;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [13:0] encode(input logic [9:0] d);
    int dpos [10];
    logic [13:0] c;
    logic p;
    dpos = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14};
    c = '0;
    for (int i = 0; i < 10; i++) c[dpos[i]-1] = d[i];
    for (int b = 0; b < 4; b++) begin
      p = 1'b0;
      for (int q = 1; q <= 14; q++) if (((q >> b) & 1) == 1) p ^= c[q-1];
      c[(1 << b) - 1] = p;
    end
    return c;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_live = 1; m_ready = 1; m_valid = 0; m_data = '0; m_err = 0;
      m_mode = 1; m_clean = 0; m_cnt = 0; m_remain = 0;
    end else if (m_live) begin
      m_valid = 0;
      if (m_remain > 0) begin
        m_remain--;
        if (m_remain == 0) begin
          m_valid = 1; m_data = m_pdata; m_err = m_perr; m_ready = 1;
          if (m_perr && m_cnt < (1 << CNT_W) - 1) m_cnt++;
          if (m_ptmr) begin
            if (m_perr) m_clean = 0;
            else begin
              m_clean++;
              if (m_clean >= CLEAN_TH) begin m_mode = 0; m_clean = 0; end
            end
          end else if (m_perr) begin
            m_mode = 1; m_clean = 0;
          end
        end
      end else if (bus.in_valid) begin
        m_ptmr = m_mode;
        m_ready = 0;
        if (m_mode) begin
          for (int b = 0; b < 10; b++)
            m_pdata[b] = (int'(stim_d[0][b]) + int'(stim_d[1][b]) + int'(stim_d[2][b])) >= 2;
          m_perr = stim_f[0] | stim_f[1] | stim_f[2] |
                   (stim_d[0] != stim_d[1]) | (stim_d[1] != stim_d[2]);
          m_remain = 4;
        end else begin
          m_pdata = stim_d[0];
          m_perr  = stim_f[0];
          m_remain = 2;
        end
      end
`ifdef TMR_FORCE_EN
      if (bus.force_tmr) begin m_mode = 1; m_clean = 0; end
`endif
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("model_in_ready", 32'(bus.in_ready), 32'(m_ready));
      chk("model_out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("model_out_data", 32'(bus.out_data), 32'(m_data));
      chk("model_out_err", 32'(bus.out_err), 32'(m_err));
      chk("model_mode_tmr", 32'(bus.mode_tmr), 32'(m_mode));
      chk("model_err_cnt", 32'(bus.err_cnt), 32'(m_cnt));
    end
  end

  longint t_acc = 0;

  task automatic send_cw(input logic [13:0] c0, c1, c2, input logic [9:0] d0, d1, d2,
                         input bit f0, f1, f2, input bit hold);
    int n;
    stim_d[0] = d0; stim_d[1] = d1; stim_d[2] = d2;
    stim_f[0] = f0; stim_f[1] = f1; stim_f[2] = f2;
    bus.cw0 = c0; bus.cw1 = c1; bus.cw2 = c2;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin @(negedge clk); n++; end
    if (!bus.in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: in_ready low for %0d cycles, required high", n);
      bus.in_valid = hold;
      return;
    end
    @(posedge clk);
    t_acc = $time;
    #1 bus.in_valid = hold;
  endtask

  task automatic send(input logic [9:0] d0, d1, d2, input int f0, f1, f2, input bit hold);
    logic [13:0] c0, c1, c2;
    c0 = encode(d0); c1 = encode(d1); c2 = encode(d2);
    if (f0 >= 0) c0[f0] = ~c0[f0];
    if (f1 >= 0) c1[f1] = ~c1[f1];
    if (f2 >= 0) c2[f2] = ~c2[f2];
    send_cw(c0, c1, c2, d0, d1, d2, f0 >= 0, f1 >= 0, f2 >= 0, hold);
  endtask

  task automatic wait_out(input logic [9:0] ed, input bit ee, input int elat,
                          input int emode, input int ecnt);
    int lat;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.out_valid && lat < 20);
    chk("latency", 32'(lat), 32'(elat));
    chk("lit_out_data", 32'(bus.out_data), 32'(ed));
    chk("lit_out_err", 32'(bus.out_err), 32'(ee));
    if (emode >= 0) chk("lit_mode_tmr", 32'(bus.mode_tmr), 32'(emode));
    if (ecnt >= 0) chk("lit_err_cnt", 32'(bus.err_cnt), 32'(ecnt));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint t_prev;
    int nv;
    bus.in_valid = 1'b0; bus.cw0 = '0; bus.cw1 = '0; bus.cw2 = '0;
`ifdef TMR_FORCE_EN
    bus.force_tmr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_mode_tmr", 32'(bus.mode_tmr), 32'd1);
    chk("reset_err_cnt", 32'(bus.err_cnt), 32'd0);

    send(10'h2A5, 10'h2A5, 10'h2A5, -1, -1, -1, 0);
    wait_out(10'h2A5, 0, 5, 1, 0);
    // Hand-encoded codeword for data 10'h001: d0 at position 3 sets parities 1 and 2.
    send_cw(14'h0007, 14'h0007, 14'h0007, 10'h001, 10'h001, 10'h001, 0, 0, 0, 0);
    wait_out(10'h001, 0, 5, 1, 0);
    send(10'h2A5, 10'h2A5, 10'h2A5, -1, 5, -1, 0);
    wait_out(10'h2A5, 1, 5, 1, 1);
    send(10'h3FF, 10'h3FF, 10'h000, -1, -1, -1, 0);
    wait_out(10'h3FF, 1, 5, 1, 2);

    for (int i = 0; i < 4; i++) begin
      send(10'h111 + 10'(i), 10'h111 + 10'(i), 10'h111 + 10'(i), -1, -1, -1, 0);
      wait_out(10'h111 + 10'(i), 0, 5, (i == 3) ? 0 : 1, 2);
    end
    send(10'h155, 10'h0AA, 10'h3C0, -1, 3, 7, 0);
    wait_out(10'h155, 0, 3, 0, 2);
    send(10'h0F0, 10'h0F0, 10'h0F0, 0, -1, -1, 0);
    wait_out(10'h0F0, 1, 3, 1, 3);
    send(10'h2A5, 10'h2A5, 10'h2A5, -1, -1, -1, 0);
    wait_out(10'h2A5, 0, 5, 1, 3);

    send(10'h123, 10'h123, 10'h123, -1, -1, -1, 1);
    t_prev = t_acc;
    wait_out(10'h123, 0, 5, 1, 3);
    send(10'h321, 10'h321, 10'h321, -1, -1, 9, 1);
    chk("b2b_interval", 32'((t_acc - t_prev) / 10), 32'd5);
    t_prev = t_acc;
    wait_out(10'h321, 1, 5, 1, 4);
    send(10'h05A, 10'h05A, 10'h05A, -1, -1, -1, 0);
    chk("b2b_interval", 32'((t_acc - t_prev) / 10), 32'd5);
    wait_out(10'h05A, 0, 5, 1, 4);

    send(10'h3FF, 10'h3FF, 10'h3FF, 2, -1, -1, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    nv = 0;
    repeat (8) begin @(negedge clk); if (bus.out_valid) nv++; end
    chk("abort_out_valid", 32'(nv), 32'd0);
    chk("abort_out_data", 32'(bus.out_data), 32'd0);
    chk("abort_out_err", 32'(bus.out_err), 32'd0);
    chk("abort_mode_tmr", 32'(bus.mode_tmr), 32'd1);
    chk("abort_err_cnt", 32'(bus.err_cnt), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 300; i++) begin
      logic [9:0] d;
      d = 10'(i * 37);
      send(d, d, d, (i % 3 == 0) ? i % 14 : -1, (i % 3 == 1) ? i % 14 : -1,
           (i % 3 == 2) ? i % 14 : -1, 0);
      wait_out(d, 1, 5, 1, -1);
    end
    chk("sat_err_cnt", 32'(bus.err_cnt), 32'hFF);

`ifdef TMR_FORCE_EN
    bus.force_tmr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(10'h1C7, 10'h1C7, 10'h1C7, -1, -1, -1, 0);
      wait_out(10'h1C7, 0, 5, 1, 255);
    end
    chk("force_mode_tmr", 32'(bus.mode_tmr), 32'd1);
    bus.force_tmr = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

`default_nettype wire
